// File: rtl/memmap_paged.sv
// Paged Z80 memory mapper: per-window page registers loaded over I/O, chip-select decode,
// RAM write protection with a sticky violation flag and a saturating violation counter.
module memmap_paged #(
    parameter int              NWIN       = 4,
    parameter int              PGW        = 8,
    parameter int              CPB        = 5,
    parameter int              NCS        = 4,
    parameter logic [NWIN-1:0] FIXED_MASK = 4'b0011,
    parameter logic [NWIN-1:0] RAMW_MASK  = 4'b0010,
    parameter int              RO_PAGES   = 2,
    parameter logic [7:0]      PORT_PG    = 8'h10,
    parameter logic [7:0]      PORT_MODE  = 8'h18
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [15:0]    za,
    input  logic [7:0]     zd_in,
    input  logic           mreq_n,
    input  logic           iorq_n,
    input  logic           rd_n,
    input  logic           wr_n,
    output logic [7:0]     io_dout,
    output logic           io_dout_en,
    output logic [CPB-1:0] mema,
    output logic           romhi,
    output logic [NCS-1:0] ramcs_n,
    output logic           romcs_n,
    output logic           memoe_n,
    output logic           memwe_n,
    output logic           viol
);
    localparam int WB = $clog2(NWIN);
    localparam int CSB = $clog2(NCS);
    localparam logic [PGW-2:0] RO_LIM = (PGW-1)'(RO_PAGES);

    logic [PGW-1:0] pg_q [NWIN];
    logic [PGW-1:0] pg_d [NWIN];
    logic           norom_q, norom_d;
    logic           ramro_q, ramro_d;
    logic           viol_q, viol_d;
    logic [7:0]     vcnt_q, vcnt_d;

    logic [1:0] iows_sync_q, mws_sync_q;
    logic       iows_edge_q, mws_edge_q;
    logic       iow_pulse, mw_pulse;

    logic [WB-1:0]  win;
    logic [PGW-1:0] p;
    logic [CSB-1:0] chip;
    logic           rom_sel, prot, mode_wr, clr, viol_ev;
    logic           unused_za;

    assign unused_za = ^za[15-WB:8];

    // Strobes are asynchronous: two-flop synchroniser, then a falling-edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iows_sync_q <= 2'b11;
            mws_sync_q  <= 2'b11;
            iows_edge_q <= 1'b1;
            mws_edge_q  <= 1'b1;
        end else begin
            iows_sync_q <= {iows_sync_q[0], iorq_n | wr_n};
            mws_sync_q  <= {mws_sync_q[0], mreq_n | wr_n};
            iows_edge_q <= iows_sync_q[1];
            mws_edge_q  <= mws_sync_q[1];
        end
    end

    assign iow_pulse = iows_edge_q & ~iows_sync_q[1];
    assign mw_pulse  = mws_edge_q & ~mws_sync_q[1];

    assign win     = za[15 -: WB];
    assign p       = pg_q[win];
    assign chip    = p[CPB +: CSB];
    assign mema    = p[CPB-1:0];
    assign romhi   = p[PGW-1];
    assign rom_sel = ~norom_q & ~RAMW_MASK[win];
    assign romcs_n = ~rom_sel;
    assign prot    = norom_q & ramro_q & ~rom_sel & (p[PGW-2:0] < RO_LIM);
    assign memoe_n = mreq_n | rd_n;
    assign memwe_n = prot | mreq_n | wr_n;
    assign viol    = viol_q;

    always_comb begin
        ramcs_n = '1;
        if (!rom_sel) ramcs_n[chip] = 1'b0;
    end

    always_comb begin
        io_dout    = 8'h00;
        io_dout_en = 1'b0;
        if (!iorq_n && !rd_n) begin
            for (int w = 0; w < NWIN; w++) begin
                if (za[7:0] == PORT_PG + 8'(w)) begin
                    io_dout_en = 1'b1;
                    io_dout    = 8'(pg_q[w]);
                end
            end
            if (za[7:0] == PORT_MODE) begin
                io_dout_en = 1'b1;
                io_dout    = {viol_q, 5'b0, ramro_q, norom_q};
            end
            if (za[7:0] == PORT_MODE + 8'd1) begin
                io_dout_en = 1'b1;
                io_dout    = vcnt_q;
            end
        end
    end

    assign mode_wr = iow_pulse && (za[7:0] == PORT_MODE);
    assign clr     = mode_wr & zd_in[7];
    assign viol_ev = mw_pulse & prot;

    always_comb begin
        pg_d    = pg_q;
        norom_d = norom_q;
        ramro_d = ramro_q;
        viol_d  = viol_q;
        vcnt_d  = vcnt_q;
        for (int w = 0; w < NWIN; w++) begin
            if (iow_pulse && (za[7:0] == PORT_PG + 8'(w)) && !FIXED_MASK[w])
                pg_d[w] = zd_in[PGW-1:0];
        end
        if (mode_wr) begin
            norom_d = zd_in[0];
            ramro_d = zd_in[1];
        end
        if (clr) begin
            viol_d = 1'b0;
            vcnt_d = 8'd0;
        end
        // A violation coinciding with a clear is counted as the first one after the clear.
        if (viol_ev) begin
            viol_d = 1'b1;
            if (clr)                 vcnt_d = 8'd1;
            else if (vcnt_q != 8'hFF) vcnt_d = vcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < NWIN; w++)
                pg_q[w] <= (w == 1) ? PGW'(3) : PGW'(0);
            norom_q <= 1'b0;
            ramro_q <= 1'b0;
            viol_q  <= 1'b0;
            vcnt_q  <= 8'd0;
        end else begin
            pg_q    <= pg_d;
            norom_q <= norom_d;
            ramro_q <= ramro_d;
            viol_q  <= viol_d;
            vcnt_q  <= vcnt_d;
        end
    end
endmodule

// File: tb/tb_memmap_paged.sv
// Directed bench for memmap_paged: expected values go into a scoreboard queue as each
// stimulus step is issued and are popped when the DUT response is sampled.
module tb_memmap_paged;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] za;
    logic [7:0]  zd_in;
    logic        mreq_n, iorq_n, rd_n, wr_n;
    logic [7:0]  io_dout;
    logic        io_dout_en;
    logic [4:0]  mema;
    logic        romhi;
    logic [3:0]  ramcs_n;
    logic        romcs_n, memoe_n, memwe_n, viol;

    memmap_paged dut (
        .clk(clk), .rst(rst), .za(za), .zd_in(zd_in),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .io_dout(io_dout), .io_dout_en(io_dout_en), .mema(mema), .romhi(romhi),
        .ramcs_n(ramcs_n), .romcs_n(romcs_n), .memoe_n(memoe_n), .memwe_n(memwe_n),
        .viol(viol)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  rd_d;
    logic        rd_en;
    logic        we_seen;

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    task automatic idle();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic io_rd(input logic [15:0] a, output logic [7:0] d, output logic en);
        @(negedge clk);
        za = a; iorq_n = 1'b0; rd_n = 1'b0;
        #2;
        d = io_dout; en = io_dout_en;
        idle();
    endtask

    task automatic mem_rd(input logic [15:0] a);
        @(negedge clk);
        za = a; mreq_n = 1'b0; rd_n = 1'b0;
        #2;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d, input logic io,
                          input logic mem, output logic we);
        @(negedge clk);
        za = a; zd_in = d; iorq_n = ~io; mreq_n = ~mem; wr_n = 1'b0;
        #2 we = memwe_n;
        repeat (4) @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; za = 16'h0000; zd_in = 8'h00;
        idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state and default decode.
        push(32'h0); push(32'h0); mem_rd(16'h0000);
        chk("rst_rom_w0", romcs_n); chk("rst_memoe", memoe_n);
        push(32'h1); push(32'hE); push(32'h3); mem_rd(16'h4000);
        chk("rst_rom_w1", romcs_n); chk("rst_ramcs_w1", ramcs_n); chk("rst_mema_w1", mema);
        push(32'h0); mem_rd(16'h8000);
        chk("rst_rom_w2", romcs_n);
        idle();
        push(32'h0); chk("rst_viol", viol);
        push(32'h00); push(32'h1); io_rd(16'h0018, rd_d, rd_en);
        chk("rst_mode_rd", rd_d); chk("rst_mode_en", rd_en);
        push(32'h00); io_rd(16'h0019, rd_d, rd_en); chk("rst_vcnt", rd_d);
        push(32'h0); push(32'h00); io_rd(16'h0020, rd_d, rd_en);
        chk("unmapped_en", rd_en); chk("unmapped_dout", rd_d);

        // Page write latency: window-2 address with port 0x12 shows pg[2] on mema.
        push(32'h0); push(32'h7);
        @(negedge clk);
        za = 16'h8012; zd_in = 8'h47; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("pg_after_2clk", mema);
        @(posedge clk);
        #1 chk("pg_after_3clk", mema);
        @(negedge clk); idle();
        repeat (3) @(negedge clk);

        bus_wr(16'h0018, 8'h01, 1'b1, 1'b0, we_seen);
        push(32'h07); push(32'hB); push(32'h0); push(32'h1); mem_rd(16'h8000);
        chk("norom_mema", mema); chk("norom_ramcs", ramcs_n);
        chk("norom_romhi", romhi); chk("norom_romcs", romcs_n);
        idle();
        push(32'h47); push(32'h1); io_rd(16'h0012, rd_d, rd_en);
        chk("pg2_rd", rd_d); chk("pg2_rd_en", rd_en);

        // Fixed windows ignore writes.
        bus_wr(16'h0010, 8'h55, 1'b1, 1'b0, we_seen);
        push(32'h00); io_rd(16'h0010, rd_d, rd_en); chk("fixed_w0", rd_d);
        bus_wr(16'h0011, 8'hAA, 1'b1, 1'b0, we_seen);
        push(32'h03); io_rd(16'h0011, rd_d, rd_en); chk("fixed_w1", rd_d);

        // Protection.
        bus_wr(16'h0018, 8'h03, 1'b1, 1'b0, we_seen);
        bus_wr(16'h0012, 8'h01, 1'b1, 1'b0, we_seen);
        push(32'h1); bus_wr(16'h8000, 8'hEE, 1'b0, 1'b1, we_seen);
        chk("prot_we_blocked", we_seen);
        push(32'h1); chk("prot_viol", viol);
        push(32'h83); io_rd(16'h0018, rd_d, rd_en); chk("prot_mode_rd", rd_d);
        push(32'h01); io_rd(16'h0019, rd_d, rd_en); chk("prot_vcnt1", rd_d);
        bus_wr(16'h0012, 8'h02, 1'b1, 1'b0, we_seen);
        push(32'h0); bus_wr(16'h8000, 8'hEE, 1'b0, 1'b1, we_seen);
        chk("unprot_we", we_seen);
        push(32'h01); io_rd(16'h0019, rd_d, rd_en); chk("unprot_vcnt", rd_d);

        // Clear, saturation, and violation racing a clear.
        bus_wr(16'h0018, 8'h83, 1'b1, 1'b0, we_seen);
        push(32'h00); io_rd(16'h0019, rd_d, rd_en); chk("clr_vcnt", rd_d);
        push(32'h0); chk("clr_viol", viol);
        push(32'h03); io_rd(16'h0018, rd_d, rd_en); chk("clr_mode_rd", rd_d);
        bus_wr(16'h0012, 8'h01, 1'b1, 1'b0, we_seen);
        for (int i = 0; i < 300; i++) bus_wr(16'h8000, 8'h00, 1'b0, 1'b1, we_seen);
        push(32'hFF); io_rd(16'h0019, rd_d, rd_en); chk("vcnt_sat", rd_d);
        bus_wr(16'h8018, 8'h83, 1'b1, 1'b1, we_seen);
        push(32'h01); io_rd(16'h0019, rd_d, rd_en); chk("race_vcnt", rd_d);
        push(32'h83); io_rd(16'h0018, rd_d, rd_en); chk("race_mode_rd", rd_d);
        push(32'h1); chk("race_viol", viol);

        // Reset in the middle of an I/O write strobe.
        @(negedge clk);
        za = 16'h8012; zd_in = 8'h99; iorq_n = 1'b0; wr_n = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        push(32'h00); push(32'h0);
        #1 chk("rst_async_mema", mema); chk("rst_async_viol", viol);
        @(negedge clk); idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        push(32'h00); io_rd(16'h0012, rd_d, rd_en); chk("rst_mid_pg2", rd_d);
        push(32'h03); io_rd(16'h0011, rd_d, rd_en); chk("rst_mid_pg1", rd_d);
        push(32'h00); io_rd(16'h0018, rd_d, rd_en); chk("rst_mid_mode", rd_d);
        push(32'h00); io_rd(16'h0019, rd_d, rd_en); chk("rst_mid_vcnt", rd_d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
